pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined RV32 core. It keeps a shadow scoreboard
//  (valid, rd, regwrite, memread) of every in-flight instruction past ID. From that it drives

---
 rtl/pipe_hazard_unit_pkg.sv | 22 ++
 rtl/pipe_hazard_unit_hazard_slot_pipe.sv | 68 ++++++
 rtl/pipe_hazard_unit.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared constants for the hazard/forwarding controller and its slot pipe.
package pipe_hazard_unit_pkg;

  // Forward-select code meaning "take operand from the register file".
  localparam int FWD_REGFILE = 0;

  // Default register-address width (RV32: x0..x31).
  localparam int DEF_REG_AW = 5;

  // Packed slot layout {valid, regwrite, memread, rd[aw-1:0]} offsets.
  localparam int SLOT_RD_LSB = 0;
  function automatic int slot_memread_bit(input int aw);
    return aw;
  endfunction
  function automatic int slot_regwrite_bit(input int aw);
    return aw + 1;
  endfunction
  function automatic int slot_valid_bit(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_hazard_slot_pipe.sv
// Shadow scoreboard of in-flight instructions past ID: a FWD_STAGES-deep
// shift register of {valid, rd, regwrite, memread}, with the slots fed by
// killed younger instructions invalidated on a redirect.
module hazard_slot_pipe
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW        = DEF_REG_AW,
  parameter int FWD_STAGES    = 3,
  parameter int REDIRECT_SLOT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid_i,
  input  logic [REG_AW-1:0]                    in_rd_i,
  input  logic                                 in_regwrite_i,
  input  logic                                 in_memread_i,
  input  logic                                 kill_i,
  output logic [FWD_STAGES-1:0]                valid_o,
  output logic [FWD_STAGES-1:0][REG_AW-1:0]    rd_o,
  output logic [FWD_STAGES-1:0]                regwrite_o,
  output logic [FWD_STAGES-1:0]                memread_o
);

  logic [FWD_STAGES-1:0]             valid_d, valid_q;
  logic [FWD_STAGES-1:0][REG_AW-1:0] rd_d, rd_q;
  logic [FWD_STAGES-1:0]             regwrite_d, regwrite_q;
  logic [FWD_STAGES-1:0]             memread_d, memread_q;

  // Next slot contents: slot0 takes the (already gated) ID fields, the rest
  // shift down; slots 1..REDIRECT_SLOT drop their incoming entry on kill.
  always_comb begin
    valid_d    = '0;
    rd_d       = '0;
    regwrite_d = '0;
    memread_d  = '0;
    valid_d[0]    = in_valid_i;
    rd_d[0]       = in_valid_i ? in_rd_i : '0;
    regwrite_d[0] = in_valid_i & in_regwrite_i;
    memread_d[0]  = in_valid_i & in_memread_i;
    for (int i = 1; i < FWD_STAGES; i++) begin
      valid_d[i]    = valid_q[i-1] & ~(kill_i && (i <= REDIRECT_SLOT));
      rd_d[i]       = rd_q[i-1];
      regwrite_d[i] = regwrite_q[i-1];
      memread_d[i]  = memread_q[i-1];
    end
  end

  // Slot registers; reset empties the whole window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= '0;
      memread_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  assign valid_o    = valid_q;
  assign rd_o       = rd_q;
  assign regwrite_o = regwrite_q;
  assign memread_o  = memread_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside ID: load-use stall, redirect flush,
// registered EX operand forward selects and saturating perf counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW        = DEF_REG_AW,
  parameter int FWD_STAGES    = 3,
  parameter int LOAD_LAT      = 1,
  parameter int REDIRECT_SLOT = 1,
  parameter int CNT_W         = 32,
  localparam int FW           = $clog2(FWD_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid_i,
  input  logic [REG_AW-1:0]        id_rs1_i,
  input  logic [REG_AW-1:0]        id_rs2_i,
  input  logic                     id_rs1_used_i,
  input  logic                     id_rs2_used_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic                     id_regwrite_i,
  input  logic                     id_memread_i,
  input  logic                     redirect_i,
  output logic                     pc_hold_o,
  output logic                     if_id_hold_o,
  output logic                     id_ex_bubble_o,
  output logic [REDIRECT_SLOT:0]   flush_o,
  output logic [FW-1:0]            fwd_rs1_o,
  output logic [FW-1:0]            fwd_rs2_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  logic [FWD_STAGES-1:0]             s_valid, s_regwrite, s_memread;
  logic [FWD_STAGES-1:0][REG_AW-1:0] s_rd;
  logic [FWD_STAGES-1:0]             m1, m2;
  logic                              stall;
  logic [FW-1:0]                     fwd_rs1_d, fwd_rs1_q, fwd_rs2_d, fwd_rs2_q;
  logic [CNT_W-1:0]                  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  hazard_slot_pipe #(
    .REG_AW       (REG_AW),
    .FWD_STAGES   (FWD_STAGES),
    .REDIRECT_SLOT(REDIRECT_SLOT)
  ) u_slots (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (id_valid_i & ~stall & ~redirect_i),
    .in_rd_i      (id_rd_i),
    .in_regwrite_i(id_regwrite_i),
    .in_memread_i (id_memread_i),
    .kill_i       (redirect_i),
    .valid_o      (s_valid),
    .rd_o         (s_rd),
    .regwrite_o   (s_regwrite),
    .memread_o    (s_memread)
  );

  // Per-slot producer match against each used ID source; x0 never matches.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      m1[i] = s_valid[i] & s_regwrite[i] & (s_rd[i] != '0) & id_rs1_used_i & (s_rd[i] == id_rs1_i);
      m2[i] = s_valid[i] & s_regwrite[i] & (s_rd[i] != '0) & id_rs2_used_i & (s_rd[i] == id_rs2_i);
    end
  end

  // Load-use stall: a load still too young to forward; a redirect overrides it.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < LOAD_LAT && i < FWD_STAGES; i++)
      if (s_memread[i] & (m1[i] | m2[i])) stall = 1'b1;
    stall = stall & id_valid_i & ~redirect_i;
  end

  assign pc_hold_o      = stall;
  assign if_id_hold_o   = stall;
  assign id_ex_bubble_o = stall;
  assign flush_o        = {(REDIRECT_SLOT+1){redirect_i}};

  // Forward select for the instruction entering EX: youngest producer wins,
  // last slot is left to the write-before-read register file.
  always_comb begin
    fwd_rs1_d = FW'(FWD_REGFILE);
    fwd_rs2_d = FW'(FWD_REGFILE);
    for (int i = FWD_STAGES - 2; i >= 0; i--) begin
      if (m1[i]) fwd_rs1_d = FW'(i + 1);
      if (m2[i]) fwd_rs2_d = FW'(i + 1);
    end
    if (stall | redirect_i) begin
      fwd_rs1_d = FW'(FWD_REGFILE);
      fwd_rs2_d = FW'(FWD_REGFILE);
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q))      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_i && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Forward-select and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rs1_q   <= '0;
      fwd_rs2_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_rs1_q   <= fwd_rs1_d;
      fwd_rs2_q   <= fwd_rs2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_rs1_o   = fwd_rs1_q;
  assign fwd_rs2_o   = fwd_rs2_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a 32-bit-counter instance plus a
// 4-bit-counter instance on the same stimulus; registered results are
// queued when driven and compared after the clock edge.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, u1 = 1'b0, u2 = 1'b0, rw = 1'b0, mr = 1'b0, redir = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic        pc_hold, if_id_hold, bubble;
  logic [1:0]  flush, f1, f2;
  logic [31:0] scnt, fcnt;
  logic        pc_hold4, if_id_hold4, bubble4;
  logic [1:0]  flush4, f14, f24;
  logic [3:0]  scnt4, fcnt4;

  int npass = 0, ntot = 0;
  logic [31:0] es = 0, ef = 0;
  logic [3:0]  es4 = 0;

  typedef struct {
    logic [1:0]  f1, f2;
    logic [31:0] sc, fc;
    logic [3:0]  sc4;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr), .redirect_i(redir), .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold),
    .id_ex_bubble_o(bubble), .flush_o(flush), .fwd_rs1_o(f1), .fwd_rs2_o(f2),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt));

  pipe_hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_memread_i(mr), .redirect_i(redir), .pc_hold_o(pc_hold4), .if_id_hold_o(if_id_hold4),
    .id_ex_bubble_o(bubble4), .flush_o(flush4), .fwd_rs1_o(f14), .fwd_rs2_o(f24),
    .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One ID cycle: drive, check combinational outputs, queue the registered
  // expectation, clock, then pop and compare.
  task automatic cyc(input string tag, input logic v, input logic [4:0] a, input logic [4:0] b,
                     input logic ua, input logic ub, input logic [4:0] d, input logic w,
                     input logic m, input logic r, input logic e_st,
                     input logic [1:0] e_f1, input logic [1:0] e_f2);
    exp_t e;
    id_valid = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; rw = w; mr = m; redir = r;
    #1;
    chk({tag, ".stall"}, {29'd0, pc_hold, if_id_hold, bubble}, {29'd0, {3{e_st}}});
    chk({tag, ".flush"}, {30'd0, flush}, {30'd0, {2{r}}});
    chk({tag, ".stall4"}, {31'd0, pc_hold4}, {31'd0, e_st});
    if (e_st) begin
      es  = es + 1;
      es4 = (es4 == 4'hF) ? 4'hF : es4 + 1'b1;
    end
    if (r) ef = ef + 1;
    e.f1 = e_f1; e.f2 = e_f2; e.sc = es; e.fc = ef; e.sc4 = es4;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk({tag, ".fwd1"}, {30'd0, f1}, {30'd0, e.f1});
    chk({tag, ".fwd2"}, {30'd0, f2}, {30'd0, e.f2});
    chk({tag, ".scnt"}, scnt, e.sc);
    chk({tag, ".fcnt"}, fcnt, e.fc);
    chk({tag, ".scnt4"}, {28'd0, scnt4}, {28'd0, e.sc4});
  endtask

  task automatic alu(input string tag, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                     input logic e_st, input logic [1:0] e_f1, input logic [1:0] e_f2);
    cyc(tag, 1, a, b, 1, 1, d, 1, 0, 0, e_st, e_f1, e_f2);
  endtask

  task automatic ld(input string tag, input logic [4:0] d, input logic [4:0] a);
    cyc(tag, 1, a, 5'd0, 1, 0, d, 1, 1, 0, 0, 2'd0, 2'd0);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) cyc("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".hold"}, {29'd0, pc_hold, if_id_hold, bubble}, 32'd0);
    chk({tag, ".flush"}, {30'd0, flush}, 32'd0);
    chk({tag, ".fwd"}, {28'd0, f1, f2}, 32'd0);
    chk({tag, ".cnt"}, scnt | fcnt, 32'd0);
    chk({tag, ".cnt4"}, {24'd0, scnt4, fcnt4}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: back-to-back ALU dependency forwards from EX result (slot1)
    alu("t1.add5", 5, 1, 2, 0, 0, 0);
    alu("t1.add6", 6, 5, 1, 0, 1, 0);
    nops(3);

    // 2: load-use -> one stall, then forward from MEM (slot2)
    ld ("t2.lw5", 5, 1);
    alu("t2.use_st", 6, 5, 5, 1, 0, 0);
    alu("t2.use_go", 6, 5, 5, 0, 2, 2);
    nops(3);

    // 3: one gap forwards from slot2, two gaps go to the register file
    alu("t3.add5a", 5, 1, 2, 0, 0, 0);
    nops(1);
    alu("t3.sub7a", 7, 1, 5, 0, 0, 2);
    nops(3);
    alu("t3.add5b", 5, 1, 2, 0, 0, 0);
    nops(2);
    alu("t3.sub7b", 7, 1, 5, 0, 0, 0);
    nops(3);

    // youngest producer wins over an older one
    alu("yw.add5a", 5, 1, 2, 0, 0, 0);
    alu("yw.add5b", 5, 1, 2, 0, 0, 0);
    alu("yw.use", 8, 5, 5, 0, 1, 1);
    nops(3);

    // 4: x0 never stalls or forwards
    alu("t4.add0", 0, 1, 2, 0, 0, 0);
    alu("t4.rd0a", 6, 0, 0, 0, 0, 0);
    nops(3);
    ld ("t4.lw0", 0, 1);
    alu("t4.rd0b", 6, 0, 0, 0, 0, 0);
    nops(3);

    // 5: redirect beats a pending load-use stall and kills the load in flight
    ld ("t5.lw5", 5, 1);
    cyc("t5.redir", 1, 5, 2, 1, 1, 6, 1, 0, 1, 0, 2'd0, 2'd0);
    alu("t5.after", 6, 5, 2, 0, 0, 0);
    nops(3);

    // 6: 20 load-use stalls saturate the 4-bit counter at F
    for (int k = 0; k < 20; k++) begin
      ld ("t6.lw9", 9, 1);
      alu("t6.st", 10, 9, 0, 1, 0, 0);
      alu("t6.go", 10, 9, 0, 0, 2, 0);
    end

    // mid-stream reset with a stall pending clears everything at once
    ld("t6.lw9r", 9, 1);
    id_valid = 1; rs1 = 9; rs2 = 0; u1 = 1; u2 = 1; rd = 10; rw = 1; mr = 0; redir = 0;
    #1;
    chk("pre_rst.stall", {31'd0, pc_hold}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    es = 0; ef = 0; es4 = 0;
    rst = 1'b0;
    alu("post_rst", 10, 9, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
